// File: rtl/cfg_axil_master.sv
// Single-outstanding AXI4-Lite master for the UDT configure register block.
// Define CFG_MASTER_TIMEOUT_EN to build in the no-answer watchdog.
module cfg_axil_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ctrl_m_axi_aclk,
  input  logic        ctrl_m_axi_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [7:0]  err_cnt,
  output logic [31:0] ctrl_m_axi_awaddr,
  output logic        ctrl_m_axi_awvalid,
  input  logic        ctrl_m_axi_awready,
  output logic [31:0] ctrl_m_axi_wdata,
  output logic [3:0]  ctrl_m_axi_wstrb,
  output logic        ctrl_m_axi_wvalid,
  input  logic        ctrl_m_axi_wready,
  input  logic [1:0]  ctrl_m_axi_bresp,
  input  logic        ctrl_m_axi_bvalid,
  output logic        ctrl_m_axi_bready,
  output logic [31:0] ctrl_m_axi_araddr,
  output logic        ctrl_m_axi_arvalid,
  input  logic        ctrl_m_axi_arready,
  input  logic [31:0] ctrl_m_axi_rdata,
  input  logic [1:0]  ctrl_m_axi_rresp,
  input  logic        ctrl_m_axi_rvalid,
  output logic        ctrl_m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        up;
  logic        aw_done;
  logic        w_done;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;
  logic [7:0]  err_q;

  logic acc;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic b_hs;
  logic r_hs;
  logic aw_ok;
  logic w_ok;
  logic abort;
  logic expire;
  logic err_hit;

  // up holds cmd_ready low until the first clock after reset release
  assign cmd_ready = up && (state == IDLE);
  assign acc       = cmd_valid && cmd_ready;

  assign ctrl_m_axi_awvalid = (state == WR) && !aw_done;
  assign ctrl_m_axi_wvalid  = (state == WR) && !w_done;
  assign ctrl_m_axi_arvalid = (state == RD_A);
  assign ctrl_m_axi_bready  = (state == WR_B);
  assign ctrl_m_axi_rready  = (state == RD_R);
  assign rsp_valid          = (state == RESP);

  assign ctrl_m_axi_awaddr = addr_q;
  assign ctrl_m_axi_araddr = addr_q;
  assign ctrl_m_axi_wdata  = wdata_q;
  assign ctrl_m_axi_wstrb  = wstrb_q;
  assign rsp_rdata         = rdata_q;
  assign rsp_resp          = resp_q;
  assign err_cnt           = err_q;

  assign aw_hs = ctrl_m_axi_awvalid && ctrl_m_axi_awready;
  assign w_hs  = ctrl_m_axi_wvalid && ctrl_m_axi_wready;
  assign ar_hs = ctrl_m_axi_arvalid && ctrl_m_axi_arready;
  assign b_hs  = ctrl_m_axi_bready && ctrl_m_axi_bvalid;
  assign r_hs  = ctrl_m_axi_rready && ctrl_m_axi_rvalid;
  assign aw_ok = aw_done || aw_hs;
  assign w_ok  = w_done || w_hs;

  assign err_hit = (b_hs && (ctrl_m_axi_bresp != 2'b00))
                || (r_hs && (ctrl_m_axi_rresp != 2'b00))
                || abort;

`ifdef CFG_MASTER_TIMEOUT_EN
  logic [15:0] cnt;
  logic        busy;
  logic        to_q;

  assign busy = (state != IDLE) && (state != RESP);
  assign expire = busy && (cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = to_q;

  always_ff @(posedge ctrl_m_axi_aclk or negedge ctrl_m_axi_aresetn) begin
    if (!ctrl_m_axi_aresetn) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      if (acc) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + 16'd1;
      end
      if (b_hs || r_hs) begin
        to_q <= 1'b0;
      end else if (abort) begin
        to_q <= 1'b1;
      end
    end
  end
`else
  assign expire = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge ctrl_m_axi_aclk or negedge ctrl_m_axi_aresetn) begin
    if (!ctrl_m_axi_aresetn) begin
      state <= IDLE;
      up    <= 1'b0;
    end else begin
      state <= state_n;
      up    <= 1'b1;
    end
  end

  // a completing handshake always beats a same-cycle watchdog expiry
  always_comb begin
    state_n = state;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          state_n = cmd_write ? WR : RD_A;
        end
      end
      WR: begin
        if (aw_ok && w_ok) begin
          state_n = WR_B;
        end else if (expire) begin
          state_n = RESP;
          abort   = 1'b1;
        end
      end
      WR_B: begin
        if (b_hs) begin
          state_n = RESP;
        end else if (expire) begin
          state_n = RESP;
          abort   = 1'b1;
        end
      end
      RD_A: begin
        if (ar_hs) begin
          state_n = RD_R;
        end else if (expire) begin
          state_n = RESP;
          abort   = 1'b1;
        end
      end
      RD_R: begin
        if (r_hs) begin
          state_n = RESP;
        end else if (expire) begin
          state_n = RESP;
          abort   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ctrl_m_axi_aclk or negedge ctrl_m_axi_aresetn) begin
    if (!ctrl_m_axi_aresetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      err_q   <= '0;
    end else begin
      if (acc) begin
        addr_q  <= cmd_addr & 32'hFFFF_FFFC;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs) w_done <= 1'b1;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= ctrl_m_axi_bresp;
      end else if (r_hs) begin
        rdata_q <= ctrl_m_axi_rdata;
        resp_q  <= ctrl_m_axi_rresp;
      end else if (abort) begin
        rdata_q <= '0;
        resp_q  <= 2'b10;
      end
      if (err_hit && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

endmodule
